imem_prog_loader: RTL

Program loader for the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit instruction words. Each word is written sequentially into instruction memory from word address 0. The core is held in reset until the whole program is loaded, so the core's fetch path reads exactly what this block writes.

---
 rtl/imem_prog_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_prog_loader.sv
// Byte-stream program loader for the MIPS instruction memory: packs bytes big-endian into words.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_prog_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words
);

  localparam int unsigned WORDS_W = ADDR_W + 1;
  localparam logic [WORDS_W-1:0] CAP = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_LOAD, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_LOAD, S_DONE, S_ERR} state_t;
`endif

  state_t               state, state_n;
  logic [1:0]           cnt, cnt_n;
  logic [31:0]          asm_word, asm_n;
  logic [WORDS_W-1:0]   words_n;
  logic                 ready_n, we_n, cpu_reset_n, done_n, err_n;
  logic [ADDR_W-1:0]    addr_n;
  logic [31:0]          wdata_n;
  logic [4:0]           shamt;
  logic [31:0]          word_c;
  logic                 accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum, csum_n;
`endif

  // New byte lands at its big-endian slot; unfilled low bytes stay zero as padding
  assign shamt  = 5'd24 - {cnt, 3'b000};
  assign word_c = asm_word | (32'(in_data) << shamt);
  assign accept = in_valid & in_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_LOAD;
      cnt       <= 2'd0;
      asm_word  <= 32'd0;
      words     <= '0;
      in_ready  <= 1'b0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= 32'd0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      asm_word  <= asm_n;
      words     <= words_n;
      in_ready  <= ready_n;
      im_we     <= we_n;
      im_addr   <= addr_n;
      im_wdata  <= wdata_n;
      cpu_reset <= cpu_reset_n;
      done      <= done_n;
      err       <= err_n;
`ifdef LOADER_CHECKSUM_EN
      csum      <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    asm_n   = asm_word;
    words_n = words;
    we_n    = 1'b0;
    addr_n  = im_addr;
    wdata_n = im_wdata;
`ifdef LOADER_CHECKSUM_EN
    csum_n  = csum;
`endif
    case (state)
      S_LOAD: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_n = csum ^ in_data;
`endif
          if (cnt == 2'd3 || in_last) begin
            cnt_n = 2'd0;
            asm_n = 32'd0;
            // Capacity check comes first so a full memory is never overwritten
            if (words == CAP) begin
              state_n = S_ERR;
            end else begin
              we_n    = 1'b1;
              addr_n  = words[ADDR_W-1:0];
              wdata_n = word_c;
              words_n = words + WORDS_W'(1);
              if (in_last) begin
`ifdef LOADER_CHECKSUM_EN
                state_n = S_CHK;
`else
                state_n = S_DONE;
`endif
              end
            end
          end else begin
            cnt_n = cnt + 2'd1;
            asm_n = word_c;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_n = (in_data == csum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: ;
    endcase
`ifdef LOADER_CHECKSUM_EN
    ready_n = (state_n == S_LOAD) || (state_n == S_CHK);
`else
    ready_n = (state_n == S_LOAD);
`endif
    // Status follows state one cycle later so the last write lands before the core runs
    done_n      = (state == S_DONE);
    err_n       = (state == S_ERR);
    cpu_reset_n = (state != S_DONE);
  end

endmodule
